// File: rtl/cnl_sched_pkg.sv
// Shared types and constants for the quad job scheduler.
// Watchdog logic in the top is enabled by CNL_JOB_WDOG_EN.
package cnl_sched_pkg;

   localparam int C_DESC_W       = 128;
   localparam int C_WDOG_DEFAULT = 65535;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_FETCH_GNT,
      S_FETCH_DONE,
      S_CMPL_ACK,
      S_CMPL_WAIT
   } state_t;

   // States in which the scheduler waits on an external party.
   function automatic logic is_watched(state_t s);
      return (s == S_START) || (s == S_FETCH_GNT) ||
             (s == S_FETCH_DONE) || (s == S_CMPL_WAIT);
   endfunction

endpackage

// File: rtl/cnl_desc_fifo.sv
// Synchronous descriptor FIFO with head output and full/empty flags.
// A pop and a push in the same cycle are accepted even when full.
module cnl_desc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_rd;
   logic             do_wr;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cnl_quad_job_sched.sv
// Job scheduler in front of cnn_layer_accel_quad: queues descriptors,
// issues jobs, brokers fetches to DMA. Optional watchdog: CNL_JOB_WDOG_EN.
module cnl_quad_job_sched
   import cnl_sched_pkg::*;
#(
   parameter int C_DESC_DEPTH  = 4,
   parameter int C_JOB_CNT_W   = 16,
   parameter int C_WDOG_CYCLES = C_WDOG_DEFAULT
) (
   input  logic                   clk_if,
   input  logic                   rst,
   input  logic                   desc_valid,
   output logic                   desc_ready,
   input  logic [C_DESC_W-1:0]    desc_data,
   output logic                   job_start,
   input  logic                   job_accept,
   output logic [C_DESC_W-1:0]    job_parameters,
   input  logic                   job_fetch_request,
   output logic                   job_fetch_ack,
   output logic                   job_fetch_complete,
   input  logic                   job_complete,
   output logic                   job_complete_ack,
   output logic                   dma_req,
   input  logic                   dma_grant,
   input  logic                   dma_done,
   output logic                   busy,
   output logic [C_JOB_CNT_W-1:0] jobs_done,
   output logic                   wdog_err
);

   if (C_DESC_DEPTH < 2 || C_DESC_DEPTH > 16 ||
       (C_DESC_DEPTH & (C_DESC_DEPTH - 1)) != 0 ||
       C_WDOG_CYCLES < 1) begin : g_bad_param
      $error("cnl_quad_job_sched: illegal parameter value");
   end

   state_t state;
   logic   rdy_en;
   logic   fifo_full;
   logic   fifo_empty;
   logic   pop;
   logic   wr_en;
   logic   wd_trip;

   assign pop        = (state == S_START) & (job_accept | wd_trip);
   assign desc_ready = rdy_en & (~fifo_full | pop);
   assign wr_en      = desc_valid & desc_ready;
   assign busy       = (state != S_IDLE) | ~fifo_empty;

   cnl_desc_fifo #(
      .DEPTH (C_DESC_DEPTH),
      .WIDTH (C_DESC_W)
   ) u_fifo (
      .clk     (clk_if),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (desc_data),
      .rd_en   (pop),
      .head    (job_parameters),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef CNL_JOB_WDOG_EN
   localparam int WW = $clog2(C_WDOG_CYCLES + 1);

   state_t        prev;
   logic [WW-1:0] wcnt;
   logic [WW-1:0] win;
   logic          leave;

   // win = cycles spent in the current state, this one included
   assign win     = (state == prev) ? wcnt + 1'b1 : WW'(1);
   assign wd_trip = is_watched(state) & (win == WW'(C_WDOG_CYCLES));

   always_comb begin
      leave = 1'b0;
      case (state)
         S_START:      leave = job_accept;
         S_FETCH_GNT:  leave = dma_grant;
         S_FETCH_DONE: leave = dma_done;
         S_CMPL_WAIT:  leave = ~job_complete;
         default:      leave = 1'b0;
      endcase
   end

   always_ff @(posedge clk_if or posedge rst) begin
      if (rst) begin
         prev     <= S_IDLE;
         wcnt     <= '0;
         wdog_err <= 1'b0;
      end else begin
         prev <= state;
         wcnt <= is_watched(state) ? win : '0;
         if (wd_trip & ~leave) begin
            wdog_err <= 1'b1;
         end
      end
   end
`else
   assign wd_trip  = 1'b0;
   assign wdog_err = 1'b0;
`endif

   always_ff @(posedge clk_if or posedge rst) begin
      if (rst) begin
         state              <= S_IDLE;
         rdy_en             <= 1'b0;
         job_start          <= 1'b0;
         job_fetch_ack      <= 1'b0;
         job_fetch_complete <= 1'b0;
         job_complete_ack   <= 1'b0;
         dma_req            <= 1'b0;
         jobs_done          <= '0;
      end else begin
         rdy_en             <= 1'b1;
         job_fetch_ack      <= 1'b0;
         job_fetch_complete <= 1'b0;
         job_complete_ack   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state     <= S_START;
                  job_start <= 1'b1;
               end
            end
            S_START: begin
               if (job_accept) begin
                  state     <= S_RUN;
                  job_start <= 1'b0;
               end else if (wd_trip) begin
                  state     <= S_IDLE;
                  job_start <= 1'b0;
               end
            end
            // completion wins over a simultaneous fetch request
            S_RUN: begin
               if (job_complete) begin
                  state            <= S_CMPL_ACK;
                  job_complete_ack <= 1'b1;
                  jobs_done        <= jobs_done + 1'b1;
               end else if (job_fetch_request) begin
                  state   <= S_FETCH_GNT;
                  dma_req <= 1'b1;
               end
            end
            S_FETCH_GNT: begin
               if (dma_grant) begin
                  state         <= S_FETCH_DONE;
                  dma_req       <= 1'b0;
                  job_fetch_ack <= 1'b1;
               end else if (wd_trip) begin
                  state   <= S_IDLE;
                  dma_req <= 1'b0;
               end
            end
            S_FETCH_DONE: begin
               if (dma_done) begin
                  state              <= S_RUN;
                  job_fetch_complete <= 1'b1;
               end else if (wd_trip) begin
                  state <= S_IDLE;
               end
            end
            S_CMPL_ACK: begin
               state <= S_CMPL_WAIT;
            end
            S_CMPL_WAIT: begin
               if (!job_complete) begin
                  if (!fifo_empty) begin
                     state     <= S_START;
                     job_start <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (wd_trip) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnl_quad_job_sched.sv
// Self-checking bench for cnl_quad_job_sched with a queue-based model.
// Define CNL_JOB_WDOG_EN to also exercise the watchdog (limit 100).
module tb_cnl_quad_job_sched;

   localparam int JW = 4;

   logic          clk_if = 1'b0;
   logic          rst = 1'b1;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   logic [127:0]  desc_data = '0;
   logic          job_start;
   logic          job_accept = 1'b0;
   logic [127:0]  job_parameters;
   logic          job_fetch_request = 1'b0;
   logic          job_fetch_ack;
   logic          job_fetch_complete;
   logic          job_complete = 1'b0;
   logic          job_complete_ack;
   logic          dma_req;
   logic          dma_grant = 1'b0;
   logic          dma_done = 1'b0;
   logic          busy;
   logic [JW-1:0] jobs_done;
   logic          wdog_err;

   int checks = 0;
   int failures = 0;
   logic [127:0] q[$];
   int model_done = 0;

   cnl_quad_job_sched #(
      .C_DESC_DEPTH  (4),
      .C_JOB_CNT_W   (JW),
      .C_WDOG_CYCLES (100)
   ) dut (
      .clk_if             (clk_if),
      .rst                (rst),
      .desc_valid         (desc_valid),
      .desc_ready         (desc_ready),
      .desc_data          (desc_data),
      .job_start          (job_start),
      .job_accept         (job_accept),
      .job_parameters     (job_parameters),
      .job_fetch_request  (job_fetch_request),
      .job_fetch_ack      (job_fetch_ack),
      .job_fetch_complete (job_fetch_complete),
      .job_complete       (job_complete),
      .job_complete_ack   (job_complete_ack),
      .dma_req            (dma_req),
      .dma_grant          (dma_grant),
      .dma_done           (dma_done),
      .busy               (busy),
      .jobs_done          (jobs_done),
      .wdog_err           (wdog_err)
   );

   always #5 clk_if = ~clk_if;

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk_if);
      #1;
   endtask

   task automatic push(input logic [127:0] d);
      int n = 0;
      desc_valid = 1'b1;
      desc_data  = d;
      while (!desc_ready && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (desc_ready !== 1'b1) begin
         failures++;
         $display("FAIL push_timeout: desc_ready=%b want 1", desc_ready);
      end else begin
         q.push_back(d);
      end
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (!job_start && n < 300) begin
         tick();
         n++;
      end
   endtask

   task automatic quad_accept(input int dly, output int hi,
                              output logic [127:0] p, output bit stable);
      hi = 0;
      p = job_parameters;
      stable = 1'b1;
      for (int i = 0; i < dly; i++) begin
         hi++;
         if (job_parameters !== p) stable = 1'b0;
         tick();
      end
      hi++;
      job_accept = 1'b1;
      tick();
      job_accept = 1'b0;
      while (job_start && hi < 500) begin
         hi++;
         tick();
      end
   endtask

   task automatic quad_complete(output int acks, output bit first);
      job_complete = 1'b1;
      tick();
      first = job_complete_ack;
      acks = job_complete_ack ? 1 : 0;
      job_complete = 1'b0;
      tick();
      if (job_complete_ack) acks++;
   endtask

   task automatic quad_fetch(input int gdly, input int ddly,
                             output int req_hi, output bit ack_first,
                             output int acks, output int cmpl_at,
                             output int cmpls);
      req_hi = 0;
      acks = 0;
      cmpls = 0;
      cmpl_at = -1;
      job_fetch_request = 1'b1;
      tick();
      for (int i = 1; i <= gdly; i++) begin
         if (dma_req) req_hi++;
         dma_grant = (i == gdly);
         tick();
      end
      dma_grant = 1'b0;
      ack_first = job_fetch_ack;
      if (job_fetch_ack) acks++;
      if (dma_req) req_hi++;
      job_fetch_request = 1'b0;
      for (int j = 1; j <= ddly + 3; j++) begin
         dma_done = (j == ddly);
         tick();
         if (job_fetch_complete) begin
            cmpls++;
            if (cmpl_at < 0) cmpl_at = j;
         end
         if (job_fetch_ack) acks++;
         if (dma_req) req_hi++;
      end
      dma_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({desc_ready, job_start, job_fetch_ack, job_fetch_complete,
           job_complete_ack, dma_req, busy, wdog_err, jobs_done,
           job_parameters} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: ready=%b start=%b busy=%b done=%0d want all 0",
                  desc_ready, job_start, busy, jobs_done);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (desc_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready_early: desc_ready=%b want 0", desc_ready);
      end
      tick();
      checks++;
      if (desc_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready_late: desc_ready=%b want 1", desc_ready);
      end
   endtask

   task automatic test_single_job();
      int n, hi, acks;
      bit st, first;
      logic [127:0] p;
      logic [127:0] exp;
      push({16{8'hA5}});
      wait_start(n);
      checks++;
      if (job_start !== 1'b1 || n != 1) begin
         failures++;
         $display("FAIL single_latency: start=%b wait=%0d want 1/1", job_start, n);
      end
      quad_accept(3, hi, p, st);
      exp = q.pop_front();
      checks++;
      if (hi != 4) begin
         failures++;
         $display("FAIL single_start_len: cycles=%0d want 4", hi);
      end
      checks++;
      if (p !== exp || !st) begin
         failures++;
         $display("FAIL single_params: got %h stable=%b want %h", p, st, exp);
      end
      quad_complete(acks, first);
      model_done++;
      checks++;
      if (acks != 1 || !first) begin
         failures++;
         $display("FAIL single_ack: pulses=%0d first=%b want 1/1", acks, first);
      end
      checks++;
      if (jobs_done !== JW'(model_done)) begin
         failures++;
         $display("FAIL single_count: jobs_done=%0d want %0d", jobs_done, JW'(model_done));
      end
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_busy: busy=%b want 0", busy);
      end
   endtask

   task automatic test_fetch();
      int n, hi, acks, rq, fa, ca, cn;
      bit st, af, first;
      logic [127:0] p;
      logic [127:0] exp;
      push(rnd128());
      wait_start(n);
      quad_accept(0, hi, p, st);
      exp = q.pop_front();
      checks++;
      if (p !== exp) begin
         failures++;
         $display("FAIL fetch_params: got %h want %h", p, exp);
      end
      for (int k = 0; k < 3; k++) begin
         quad_fetch(5, 10, rq, af, fa, ca, cn);
         checks++;
         if (rq != 5) begin
            failures++;
            $display("FAIL fetch_req_len[%0d]: cycles=%0d want 5", k, rq);
         end
         checks++;
         if (!af || fa != 1) begin
            failures++;
            $display("FAIL fetch_ack[%0d]: first=%b pulses=%0d want 1/1", k, af, fa);
         end
         checks++;
         if (cn != 1 || ca != 10) begin
            failures++;
            $display("FAIL fetch_cmpl[%0d]: pulses=%0d at=%0d want 1 at 10", k, cn, ca);
         end
      end
      quad_complete(acks, first);
      model_done++;
      checks++;
      if (acks != 1 || jobs_done !== JW'(model_done)) begin
         failures++;
         $display("FAIL fetch_count: acks=%0d jobs_done=%0d want 1/%0d",
                  acks, jobs_done, JW'(model_done));
      end
      tick();
   endtask

   task automatic test_backpressure();
      int n, hi, acks;
      bit st, first;
      logic [127:0] p;
      logic [127:0] exp;
      for (int i = 1; i <= 4; i++) push(128'(i));
      checks++;
      if (desc_ready !== 1'b0 || job_start !== 1'b1) begin
         failures++;
         $display("FAIL bp_full: ready=%b start=%b want 0/1", desc_ready, job_start);
      end
      // push the fifth while the head is accepted
      p = job_parameters;
      desc_valid = 1'b1;
      desc_data = 128'd5;
      job_accept = 1'b1;
      #1;
      checks++;
      if (desc_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_pop_bypass: ready=%b want 1", desc_ready);
      end
      tick();
      q.push_back(128'd5);
      job_accept = 1'b0;
      desc_valid = 1'b0;
      checks++;
      if (desc_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_still_full: ready=%b want 0", desc_ready);
      end
      exp = q.pop_front();
      checks++;
      if (p !== exp) begin
         failures++;
         $display("FAIL bp_order[1]: got %0d want %0d", p, exp);
      end
      quad_complete(acks, first);
      model_done++;
      for (int j = 2; j <= 5; j++) begin
         tick();
         checks++;
         if (job_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_bubble[%0d]: start=%b busy=%b want 1/1", j, job_start, busy);
         end
         wait_start(n);
         quad_accept($urandom_range(0, 3), hi, p, st);
         exp = q.pop_front();
         checks++;
         if (p !== exp || !st) begin
            failures++;
            $display("FAIL bp_order[%0d]: got %0d want %0d", j, p, exp);
         end
         quad_complete(acks, first);
         model_done++;
      end
      checks++;
      if (jobs_done !== JW'(model_done)) begin
         failures++;
         $display("FAIL bp_count: jobs_done=%0d want %0d", jobs_done, JW'(model_done));
      end
      tick();
   endtask

   task automatic test_priority();
      int n, hi, bad;
      bit st;
      logic [127:0] p;
      logic [127:0] exp;
      push(rnd128());
      wait_start(n);
      quad_accept(1, hi, p, st);
      exp = q.pop_front();
      job_complete = 1'b1;
      job_fetch_request = 1'b1;
      tick();
      model_done++;
      checks++;
      if (job_complete_ack !== 1'b1 || dma_req !== 1'b0) begin
         failures++;
         $display("FAIL prio_ack: ack=%b dma_req=%b want 1/0", job_complete_ack, dma_req);
      end
      job_complete = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (dma_req) bad++;
      end
      job_fetch_request = 1'b0;
      checks++;
      if (bad != 0 || p !== exp) begin
         failures++;
         $display("FAIL prio_no_fetch: dma_req cycles=%0d want 0", bad);
      end
      checks++;
      if (jobs_done !== JW'(model_done)) begin
         failures++;
         $display("FAIL prio_count: jobs_done=%0d want %0d", jobs_done, JW'(model_done));
      end
   endtask

   task automatic test_reset_mid_fetch();
      int n, hi, pulses, starts;
      bit st;
      logic [127:0] p;
      for (int i = 0; i < 3; i++) push(rnd128());
      wait_start(n);
      quad_accept(0, hi, p, st);
      void'(q.pop_front());
      job_fetch_request = 1'b1;
      tick();
      dma_grant = 1'b1;
      tick();
      dma_grant = 1'b0;
      job_fetch_request = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      model_done = 0;
      checks++;
      if ({desc_ready, job_start, job_fetch_ack, job_fetch_complete,
           job_complete_ack, dma_req, busy, jobs_done} !== '0) begin
         failures++;
         $display("FAIL rst_async: ready=%b ack=%b busy=%b done=%0d want all 0",
                  desc_ready, job_fetch_ack, busy, jobs_done);
      end
      tick();
      rst = 1'b0;
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      pulses = 0;
      starts = 0;
      for (int i = 0; i < 5; i++) begin
         if (job_fetch_complete) pulses++;
         if (job_start) starts++;
         tick();
      end
      checks++;
      if (pulses != 0 || starts != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_flush: cmpl=%0d starts=%0d busy=%b want 0/0/0",
                  pulses, starts, busy);
      end
   endtask

   task automatic test_random();
      int n, hi, acks, rq, fa, ca, cn, k, nf, dd;
      bit st, af, first;
      logic [127:0] p;
      logic [127:0] exp;
      for (int r = 0; r < 30 && model_done < 20; r++) begin
         k = $urandom_range(1, 4);
         for (int i = 0; i < k; i++) push(rnd128());
         while (q.size() > 0) begin
            wait_start(n);
            checks++;
            if (job_start !== 1'b1) begin
               failures++;
               $display("FAIL rand_start_timeout: start=%b want 1", job_start);
            end
            quad_accept($urandom_range(0, 4), hi, p, st);
            exp = q.pop_front();
            checks++;
            if (p !== exp || !st) begin
               failures++;
               $display("FAIL rand_params: got %h want %h", p, exp);
            end
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
               dd = $urandom_range(1, 4);
               quad_fetch($urandom_range(1, 4), dd, rq, af, fa, ca, cn);
               checks++;
               if (!af || fa != 1 || cn != 1 || ca != dd) begin
                  failures++;
                  $display("FAIL rand_fetch: ack=%b/%0d cmpl=%0d at %0d want 1/1 1 at %0d",
                           af, fa, cn, ca, dd);
               end
            end
            quad_complete(acks, first);
            model_done++;
            checks++;
            if (acks != 1 || !first ||
                jobs_done !== JW'(model_done % (1 << JW))) begin
               failures++;
               $display("FAIL rand_done: acks=%0d jobs_done=%0d want 1/%0d",
                        acks, jobs_done, model_done % (1 << JW));
            end
         end
      end
      tick();
   endtask

`ifdef CNL_JOB_WDOG_EN
   task automatic test_watchdog();
      int n, hi, acks;
      bit st, first;
      logic [127:0] p;
      logic [127:0] exp;
      push(rnd128());
      push(rnd128());
      wait_start(n);
      hi = 0;
      while (job_start && hi < 300) begin
         hi++;
         tick();
      end
      void'(q.pop_front());
      checks++;
      if (hi != 100 || wdog_err !== 1'b1) begin
         failures++;
         $display("FAIL wdog_trip: start cycles=%0d err=%b want 100/1", hi, wdog_err);
      end
      wait_start(n);
      exp = q.pop_front();
      checks++;
      if (n != 1 || job_parameters !== exp) begin
         failures++;
         $display("FAIL wdog_next: wait=%0d head=%h want 1/%h", n, job_parameters, exp);
      end
      quad_accept(0, hi, p, st);
      quad_complete(acks, first);
      tick();
      checks++;
      if (wdog_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL wdog_sticky: err=%b busy=%b want 1/0", wdog_err, busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_job();
      test_fetch();
      test_backpressure();
      test_priority();
      test_reset_mid_fetch();
      test_random();
`ifdef CNL_JOB_WDOG_EN
      test_watchdog();
`else
      checks++;
      if (wdog_err !== 1'b0) begin
         failures++;
         $display("FAIL wdog_tied: err=%b want 0", wdog_err);
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
